// File: rtl/seg_pkg.sv
// Shared constants, converter state encoding and the double-dabble adjust step
// for the multiplexed 4-digit display driver.
package seg_pkg;

  localparam int NDIG  = 4;
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  localparam logic [3:0]       DASH_CODE = 4'hA;
  localparam logic [BIN_W-1:0] MAX_VAL   = 14'd9999;

  // One double-dabble iteration per input bit; counter stops on the last one.
  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Add 3 to every BCD nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Load/busy handshake plus the digit-code and digit-select outputs of the
// display scanner, bundled for connection between producer and scanner.
interface seg_scan_if;
  import seg_pkg::*;

  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic             busy;
  logic [3:0]       num;
  logic [NDIG-1:0]  dig_sel;

  modport master (output bin_in, output load, input busy, input num, input dig_sel);
  modport slave  (input bin_in, input load, output busy, output num, output dig_sel);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits in
// 14 shift cycles, with a one-cycle commit strobe and an out-of-range flag.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] adj;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    done    = 1'b0;
    adj     = dd_adjust(bcd_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d = bin;
          bcd_d = '0;
          cnt_d = '0;
          if (bin > MAX_VAL) begin
            ovf_d   = 1'b1;
            state_d = ST_COMMIT;
          end else begin
            ovf_d   = 1'b0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan.sv
// Display scanner: holds the committed digits, cycles the four digit slots
// on a free-running prescaler and drives registered num / dig_sel.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic             conv_busy, conv_done, conv_ovf;
  logic [BCD_W-1:0] conv_bcd;

  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       num_q, num_d;
  logic [NDIG-1:0]  dig_sel_q, dig_sel_d;
  logic [NDIG-1:0]  blank;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (bus.load),
    .bin   (bus.bin_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .ovf   (conv_ovf),
    .bcd   (conv_bcd)
  );

  // Slot i is blanked when it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run = zero_run && (digits_q[4*i +: 4] == 4'd0);
      blank[i] = LZ_BLANK && !ovf_q && zero_run;
    end
  end

  always_comb begin
    logic [NDIG-1:0] one_hot;
    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    idx_d    = (presc_q == PRESC_LAST) ? idx_q + 2'd1 : idx_q;
    digits_d = conv_done ? conv_bcd : digits_q;
    ovf_d    = conv_done ? conv_ovf : ovf_q;

    one_hot   = 4'b0001 << idx_q;
    num_d     = ovf_q ? DASH_CODE : digits_q[{idx_q, 2'b00} +: 4];
    dig_sel_d = blank[idx_q] ? 4'b1111 : ~one_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      num_q     <= 4'h0;
      dig_sel_q <= 4'b1110;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      num_q     <= num_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign bus.busy    = conv_busy;
  assign bus.num     = num_q;
  assign bus.dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed scenarios plus random loads, every cycle checked
// against a decimal-arithmetic model of the committed value and the slot schedule.
module tb_seg_scan;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if bus ();

  seg_scan #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int cyc         = 0;   // edges since time zero
  int n_run       = 0;   // non-reset edges since last reset
  int disp_val    = 0;
  bit disp_ovf    = 0;
  bit pend        = 0;
  int pend_val    = 0;
  bit pend_ovf    = 0;
  int commit_edge = 0;

  function automatic void expect_out(input int val, input bit ovf, input int slot,
                                     output logic [3:0] en, output logic [3:0] es);
    int  pow;
    bit  blank;
    pow   = 10 ** slot;
    en    = ovf ? 4'hA : 4'((val / pow) % 10);
    blank = !ovf && (slot > 0) && (val < pow);
    es    = blank ? 4'b1111 : ~(4'b0001 << slot);
  endfunction

  task automatic tick();
    logic [3:0] exp_num, exp_sel;
    bit         was_pend;
    bit         sel_ok;
    int         slot;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      n_run    = 0;
      disp_val = 0;
      disp_ovf = 0;
      pend     = 0;
      exp_num  = 4'h0;
      exp_sel  = 4'b1110;
    end else begin
      slot = (n_run / SCAN_DIV) % 4;
      expect_out(disp_val, disp_ovf, slot, exp_num, exp_sel);
      n_run++;
      was_pend = pend;
      if (pend && commit_edge == cyc) begin
        disp_val = pend_val;
        disp_ovf = pend_ovf;
        pend     = 0;
      end
      if (bus.load && !was_pend) begin
        pend = 1;
        if (int'(bus.bin_in) > 9999) begin
          pend_ovf    = 1;
          commit_edge = cyc + 1;
        end else begin
          pend_ovf    = 0;
          pend_val    = int'(bus.bin_in);
          commit_edge = cyc + 15;
        end
      end
    end

    n_vec++;
    assert (bus.busy === pend) else begin
      n_err++;
      $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, bus.busy, pend);
    end
    n_vec++;
    assert (bus.num === exp_num) else begin
      n_err++;
      $error("FAIL num cyc=%0d observed=%h expected=%h", cyc, bus.num, exp_num);
    end
    n_vec++;
    assert (bus.dig_sel === exp_sel) else begin
      n_err++;
      $error("FAIL dig_sel cyc=%0d observed=%b expected=%b", cyc, bus.dig_sel, exp_sel);
    end
    sel_ok = (bus.dig_sel === 4'b1111) || ($countones(~bus.dig_sel) == 1);
    n_vec++;
    assert (sel_ok === 1'b1) else begin
      n_err++;
      $error("FAIL sel_onehot cyc=%0d observed=%b expected=one-low-or-1111", cyc, bus.dig_sel);
    end
  endtask

  task automatic do_load(input int v);
    bus.bin_in = 14'(v);
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.bin_in = '0;
    bus.load   = 1'b0;

    // 1. reset held three clocks, then watch the first slot period
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2 * SCAN_DIV + 2);

    // 2. 1234, full scan afterwards
    do_load(1234);
    idle(16 + 4 * SCAN_DIV);

    // 3. leading-zero blanking and interior zeros
    do_load(7);
    idle(16 + 4 * SCAN_DIV);
    do_load(1005);
    idle(16 + 4 * SCAN_DIV);

    // 4. max value, overflow, recovery
    do_load(9999);
    idle(16 + 4 * SCAN_DIV);
    do_load(10000);
    idle(2 + 4 * SCAN_DIV);
    do_load(42);
    idle(16 + 4 * SCAN_DIV);

    // 5. load while busy is dropped; load on the commit edge is dropped
    do_load(555);
    idle(4);
    do_load(321);
    idle(8);
    do_load(111);
    idle(4 * SCAN_DIV + 2);
    // reset in the middle of a conversion
    do_load(888);
    idle(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(20 + 4 * SCAN_DIV);

    // 6. free-running scan over 64 clocks with an idle converter
    idle(64);

    // random loads with random spacing, some landing while busy
    for (int t = 0; t < 40; t++) begin
      do_load(int'($urandom_range(0, 16383)));
      idle(int'($urandom_range(0, 24)));
    end
    idle(16 + 4 * SCAN_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
